// File: rtl/conv_sched_ctrl.sv
// Job sequencer for the img2col tensor/weight address generators and the GEMM accumulator.
// Optional performance counters are enabled by defining CONV_SCHED_PERF_EN.
module conv_sched_ctrl #(
    parameter int TENSOR_W = 8,
    parameter int KERNEL_W = 4,
    parameter int CH_W     = 8,
    parameter int STRIDE_W = 3,
    parameter int KNUM_W   = 8,
    parameter int GEN_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TENSOR_W-1:0] tensor_size,
    input  logic [KERNEL_W-1:0] kernel_size,
    input  logic [CH_W-1:0]     channels,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [KNUM_W-1:0]   kernel_nums,
    input  logic                stall,
    output logic                busy,
    output logic                gen_enable,
    output logic                acc_valid,
    output logic                acc_first,
    output logic                acc_last,
    output logic [TENSOR_W-1:0] out_size,
    output logic                done,
    output logic                cfg_err
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_total_cycles
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0] LAT4 = 4'(GEN_LAT);

    logic [2:0]          state;
    logic [TENSOR_W-1:0] ts_r;
    logic [KERNEL_W-1:0] ks_r;
    logic [CH_W-1:0]     ch_r;
    logic [STRIDE_W-1:0] st_r;
    logic [KNUM_W-1:0]   kn_r;
    logic [TENSOR_W-1:0] rem;
    logic [TENSOR_W-1:0] q;
    logic [15:0]         k_last;
    logic [15:0]         pix_last;
    logic [KNUM_W-1:0]   kn_last;
    logic [15:0]         k_cnt;
    logic [15:0]         pix_cnt;
    logic [KNUM_W-1:0]   kn_cnt;
    logic [2:0]          drain_cnt;

    logic                cfg_bad;
    logic [15:0]         k_total;
    logic [TENSOR_W-1:0] q_next;
    logic [15:0]         p_total;
    logic                issue_first;
    logic                issue_last;
    logic                pix_wrap;
    logic                kn_wrap;
    logic                drain_end;

    always_comb begin
        cfg_bad     = (ks_r == '0) || (st_r == '0) || (ch_r == '0) || (kn_r == '0) ||
                      (TENSOR_W'(ks_r) > ts_r);
        k_total     = 16'(ks_r) * 16'(ks_r) * 16'(ch_r);
        q_next      = q + TENSOR_W'(1);
        p_total     = 16'(q_next) * 16'(q_next);
        gen_enable  = (state == S_RUN) && !stall;
        issue_first = (k_cnt == 16'd0);
        issue_last  = (k_cnt == k_last);
        pix_wrap    = (pix_cnt == pix_last);
        kn_wrap     = (kn_cnt == kn_last);
        drain_end   = ({1'b0, drain_cnt} + 4'd1) >= LAT4;
    end

    // Counters nest k (innermost), pixel, kernel; the final beat is all three at their maxima.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            out_size  <= '0;
            ts_r      <= '0;
            ks_r      <= '0;
            ch_r      <= '0;
            st_r      <= '0;
            kn_r      <= '0;
            rem       <= '0;
            q         <= '0;
            k_last    <= '0;
            pix_last  <= '0;
            kn_last   <= '0;
            k_cnt     <= '0;
            pix_cnt   <= '0;
            kn_cnt    <= '0;
            drain_cnt <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ts_r  <= tensor_size;
                        ks_r  <= kernel_size;
                        ch_r  <= channels;
                        st_r  <= stride;
                        kn_r  <= kernel_nums;
                        busy  <= 1'b1;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cfg_bad) begin
                        cfg_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        rem       <= ts_r - TENSOR_W'(ks_r);
                        q         <= '0;
                        k_last    <= k_total - 16'd1;
                        kn_last   <= kn_r - KNUM_W'(1);
                        k_cnt     <= '0;
                        pix_cnt   <= '0;
                        kn_cnt    <= '0;
                        drain_cnt <= '0;
                        state     <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (rem >= TENSOR_W'(st_r)) begin
                        rem <= rem - TENSOR_W'(st_r);
                        q   <= q_next;
                    end else begin
                        out_size <= q_next;
                        pix_last <= p_total - 16'd1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (gen_enable) begin
                        if (issue_last) begin
                            k_cnt <= '0;
                            if (pix_wrap) begin
                                pix_cnt <= '0;
                                if (kn_wrap) begin
                                    kn_cnt <= '0;
                                    state  <= S_DRAIN;
                                end else begin
                                    kn_cnt <= kn_cnt + KNUM_W'(1);
                                end
                            end else begin
                                pix_cnt <= pix_cnt + 16'd1;
                            end
                        end else begin
                            k_cnt <= k_cnt + 16'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_end) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Tags travel with the enable so the accumulator sees them alongside the generated address.
    generate
        if (GEN_LAT == 0) begin : g_no_lat
            assign acc_valid = gen_enable;
            assign acc_first = issue_first & gen_enable;
            assign acc_last  = issue_last & gen_enable;
        end else begin : g_lat
            logic [2:0] pipe [GEN_LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < GEN_LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= {gen_enable, issue_first & gen_enable, issue_last & gen_enable};
                    for (int i = 1; i < GEN_LAT; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign acc_valid = pipe[GEN_LAT-1][2];
            assign acc_first = pipe[GEN_LAT-1][1];
            assign acc_last  = pipe[GEN_LAT-1][0];
        end
    endgenerate

`ifdef CONV_SCHED_PERF_EN
    // Both counters saturate and hold after done until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_total_cycles <= '0;
        end else if (state == S_IDLE && start) begin
            perf_stall_cycles <= '0;
            perf_total_cycles <= '0;
        end else begin
            if ((state == S_CHECK || state == S_DIV || state == S_RUN || state == S_DRAIN) &&
                perf_total_cycles != '1)
                perf_total_cycles <= perf_total_cycles + 32'd1;
            if (state == S_RUN && stall && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Self-checking bench for conv_sched_ctrl: directed job table, hand-written reset sequence,
// and randomized jobs checked against an arithmetic model of the job.
module tb_conv_sched_ctrl;

    localparam int GEN_LAT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] tensor_size;
    logic [3:0] kernel_size;
    logic [7:0] channels;
    logic [2:0] stride;
    logic [7:0] kernel_nums;
    logic       stall;
    logic       busy;
    logic       gen_enable;
    logic       acc_valid;
    logic       acc_first;
    logic       acc_last;
    logic [7:0] out_size;
    logic       done;
    logic       cfg_err;

    always #5 clk = ~clk;

    conv_sched_ctrl #(
        .TENSOR_W(8), .KERNEL_W(4), .CH_W(8), .STRIDE_W(3), .KNUM_W(8), .GEN_LAT(GEN_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tensor_size(tensor_size),
        .kernel_size(kernel_size), .channels(channels), .stride(stride),
        .kernel_nums(kernel_nums), .stall(stall), .busy(busy), .gen_enable(gen_enable),
        .acc_valid(acc_valid), .acc_first(acc_first), .acc_last(acc_last),
        .out_size(out_size), .done(done), .cfg_err(cfg_err)
    );

    typedef struct {
        int ts, ks, ch, st, kn;
        int stall_beat, stall_len, reissue, rand_stall;
        int exp_err, exp_out, exp_beats, exp_tags, exp_idx;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   gen_beats = 0, acc_beats = 0, first_cnt = 0, last_cnt = 0;
    int   tag_err = 0, done_cnt = 0, err_cnt = 0;
    int   exp_k = 0;
    logic prev_gen = 1'b0;

    // Observer: counts beats and pulses, and checks tag position and one-cycle alignment.
    always @(negedge clk) begin
        if (gen_enable) gen_beats++;
        if (stall && gen_enable) tag_err++;
        if (acc_valid !== prev_gen) tag_err++;
        if (acc_valid) begin
            if (exp_k > 0) begin
                if (acc_first !== ((acc_beats % exp_k) == 0)) tag_err++;
                if (acc_last !== ((acc_beats % exp_k) == exp_k - 1)) tag_err++;
            end
            if (acc_first) first_cnt++;
            if (acc_last) last_cnt++;
            acc_beats++;
        end else if (acc_first || acc_last) begin
            tag_err++;
        end
        if (done) done_cnt++;
        if (cfg_err) err_cnt++;
        prev_gen = gen_enable && !rst;
    end

    task automatic checkOutput(input string name, input int job, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL job %0d %s: got %0d, expected %0d", job, name, act, exp);
        end
    endtask

    task automatic clearMonitor();
        gen_beats = 0; acc_beats = 0; first_cnt = 0; last_cnt = 0;
        tag_err = 0; done_cnt = 0; err_cnt = 0;
    endtask

    function automatic vec_t modelJob(input int ts, input int ks, input int ch, input int st,
                                      input int kn, input int reissue);
        vec_t v;
        int   os;
        v = '{ts, ks, ch, st, kn, 0, 0, reissue, 1, 0, 0, 0, 0, 0};
        v.exp_err = (ks == 0 || st == 0 || ch == 0 || kn == 0 || ks > ts) ? 1 : 0;
        if (v.exp_err == 0) begin
            os          = (ts - ks) / st + 1;
            v.exp_out   = os;
            v.exp_tags  = os * os * kn;
            v.exp_beats = ks * ks * ch * v.exp_tags;
            v.exp_idx   = 2 + os + v.exp_beats + ((GEN_LAT > 0) ? GEN_LAT : 1);
        end
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v, input int job);
        int cyc, stalls, stall_left, done_idx, err_idx, r, div_end;
        bit finished;
        exp_k   = (v.exp_err != 0) ? 0 : v.ks * v.ks * v.ch;
        div_end = (v.exp_err != 0) ? 0 : v.exp_out + 1;
        @(posedge clk); #1;
        clearMonitor();
        start = 1'b1; stall = 1'b0;
        tensor_size = 8'(v.ts); kernel_size = 4'(v.ks); channels = 8'(v.ch);
        stride = 3'(v.st); kernel_nums = 8'(v.kn);
        cyc = 0; stalls = 0; stall_left = 0; done_idx = -1; err_idx = -1; finished = 0;
        while (!finished && cyc < 20000) begin
            @(negedge clk);
            if (done && done_idx < 0) begin done_idx = cyc; finished = 1; end
            if (cfg_err && err_idx < 0) begin err_idx = cyc; finished = 1; end
            if (!finished) begin
                @(posedge clk); #1;
                cyc++;
                start = (v.reissue != 0 && cyc == 5);
                if (start) begin
                    tensor_size = 8'd6; kernel_size = 4'd2; channels = 8'd3;
                    stride = 3'd1; kernel_nums = 8'd2;
                end else begin
                    tensor_size = 8'($urandom); kernel_size = 4'($urandom);
                    channels = 8'($urandom); stride = 3'($urandom); kernel_nums = 8'($urandom);
                end
                if (stall_left == 0 && v.stall_len > 0 && stalls == 0 && gen_beats == v.stall_beat)
                    stall_left = v.stall_len;
                if (stall_left > 0) begin
                    stall = 1'b1; stall_left--; stalls++;
                end else if (v.rand_stall != 0) begin
                    r = ($urandom_range(0, 3) == 0) ? 1 : 0;
                    if (gen_beats > 0 && gen_beats < v.exp_beats) begin
                        stall = r[0]; stalls += r;
                    end else if (cyc <= div_end || gen_beats == v.exp_beats) begin
                        stall = r[0];
                    end else begin
                        stall = 1'b0;
                    end
                end else begin
                    stall = 1'b0;
                end
            end
        end
        start = 1'b0; stall = 1'b0;
        if (!finished) checkOutput("completion_timeout", job, 0, 1);
        repeat (3) @(negedge clk);
        if (v.exp_err != 0) begin
            checkOutput("cfg_err_cycle", job, err_idx, 2);
            checkOutput("cfg_err_count", job, err_cnt, 1);
            checkOutput("gen_beats", job, gen_beats, 0);
            checkOutput("done_count", job, done_cnt, 0);
        end else begin
            checkOutput("out_size", job, out_size, v.exp_out);
            checkOutput("gen_beats", job, gen_beats, v.exp_beats);
            checkOutput("acc_beats", job, acc_beats, v.exp_beats);
            checkOutput("acc_first_count", job, first_cnt, v.exp_tags);
            checkOutput("acc_last_count", job, last_cnt, v.exp_tags);
            checkOutput("done_count", job, done_cnt, 1);
            checkOutput("done_cycle", job, done_idx, v.exp_idx + stalls);
            checkOutput("cfg_err_count", job, err_cnt, 0);
        end
        checkOutput("tag_alignment_errors", job, tag_err, 0);
        checkOutput("busy_after", job, busy, 0);
    endtask

    task automatic resetMidRun(input int job);
        @(posedge clk); #1;
        clearMonitor();
        exp_k = 9;
        start = 1'b1; stall = 1'b0;
        tensor_size = 8'd4; kernel_size = 4'd3; channels = 8'd1; stride = 3'd1; kernel_nums = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200 && gen_beats < 10; i++) @(negedge clk);
        checkOutput("reached_run", job, (gen_beats >= 10) ? 1 : 0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", job, busy, 0);
        checkOutput("rst_gen_enable", job, gen_enable, 0);
        checkOutput("rst_acc_valid", job, acc_valid, 0);
        checkOutput("rst_acc_first", job, acc_first, 0);
        checkOutput("rst_acc_last", job, acc_last, 0);
        checkOutput("rst_out_size", job, out_size, 0);
        checkOutput("rst_done", job, done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    vec_t table_q [12];

    initial begin
        table_q[0]  = '{4, 3, 1, 1, 1,  0, 0, 0, 0,  0, 2,  36,  4,  41};
        table_q[1]  = '{5, 3, 2, 2, 3,  0, 0, 0, 0,  0, 2, 216, 12, 221};
        table_q[2]  = '{4, 3, 1, 1, 1, 10, 5, 0, 0,  0, 2,  36,  4,  41};
        table_q[3]  = '{4, 5, 1, 1, 1,  0, 0, 0, 0,  1, 0,   0,  0,   0};
        table_q[4]  = '{4, 3, 1, 0, 1,  0, 0, 0, 0,  1, 0,   0,  0,   0};
        table_q[5]  = '{4, 3, 1, 1, 1,  0, 0, 0, 0,  0, 2,  36,  4,  41};
        table_q[6]  = '{4, 3, 1, 1, 1,  0, 0, 1, 0,  0, 2,  36,  4,  41};
        table_q[7]  = '{3, 1, 1, 1, 2,  0, 0, 0, 0,  0, 3,  18, 18,  24};
        table_q[8]  = '{3, 3, 1, 1, 1,  0, 0, 0, 0,  0, 1,   9,  1,  13};
        table_q[9]  = '{4, 2, 0, 1, 1,  0, 0, 0, 0,  1, 0,   0,  0,   0};
        table_q[10] = '{4, 2, 1, 1, 0,  0, 0, 0, 0,  1, 0,   0,  0,   0};
        table_q[11] = '{6, 2, 1, 3, 1,  0, 0, 0, 1,  0, 2,  16,  4,  21};

        rst = 1'b1; start = 1'b0; stall = 1'b0;
        tensor_size = '0; kernel_size = '0; channels = '0; stride = '0; kernel_nums = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 0, busy, 0);
        checkOutput("reset_gen_enable", 0, gen_enable, 0);
        checkOutput("reset_acc_valid", 0, acc_valid, 0);
        checkOutput("reset_out_size", 0, out_size, 0);
        checkOutput("reset_done", 0, done, 0);
        checkOutput("reset_cfg_err", 0, cfg_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) applyStimulus(table_q[i], i + 1);

        resetMidRun(13);
        applyStimulus(table_q[0], 14);

        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v = modelJob($urandom_range(1, 7), $urandom_range(0, 3), $urandom_range(0, 2),
                         $urandom_range(0, 3), $urandom_range(0, 2),
                         ($urandom_range(0, 3) == 0) ? 1 : 0);
            applyStimulus(v, 100 + i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_sched_ctrl.md
Name: conv_sched_ctrl

Overview:
Job-level sequencer for the img2col address-generation pair (tensor address generator plus weight address generator) and the downstream GEMM accumulator.
- Accepts one convolution job through a start/busy/done handshake and latches its configuration.
- Validates the configuration and derives the output size by iterative subtraction.
- Drives the generators' enable for exactly the required number of cycles, honouring a memory stall.
- Emits accumulator first/last tags, delayed to align with the generated addresses.

Parameters:
TENSOR_W, 8, width of tensor_size
KERNEL_W, 4, width of kernel_size
CH_W, 8, width of channels
STRIDE_W, 3, width of stride
KNUM_W, 8, width of kernel_nums
GEN_LAT, 1, address-generator latency in cycles (enable to address valid); range 0..7

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  job request; sampled only in IDLE
tensor_size  in  TENSOR_W  input height = width
kernel_size  in  KERNEL_W  kernel height = width
channels  in  CH_W  input channels
stride  in  STRIDE_W  convolution stride
kernel_nums  in  KNUM_W  number of kernels
stall  in  1  memory not ready; freezes issue
busy  out  1  high from the cycle after an accepted start until done
gen_enable  out  1  enable to both address generators
acc_valid  out  1  address beat valid at the accumulator (gen_enable delayed GEN_LAT)
acc_first  out  1  first beat of a dot product (aligned with acc_valid)
acc_last  out  1  last beat of a dot product (aligned with acc_valid)
out_size  out  TENSOR_W  derived output height = width; valid from RUN onward
done  out  1  one-cycle pulse: job complete
cfg_err  out  1  one-cycle pulse: job rejected

Behaviour:
- Reset: every output is 0; state is IDLE; all counters and the delay line are cleared. Reset mid-job aborts it; outputs are 0 on the cycle after rst is sampled high.
- IDLE: when start=1, latch all configuration inputs, set busy, and go to CHECK. Changes to start or configuration inputs while not in IDLE are ignored.
- CHECK (1 cycle): if kernel_size, stride, channels or kernel_nums is 0, or kernel_size > tensor_size, pulse cfg_err, clear busy, and return to IDLE. gen_enable is never asserted for a rejected job. Otherwise:
  - rem = tensor_size - kernel_size; q = 0
  - K = kernel_size*kernel_size*channels (16 bits)
  - go to DIV
- DIV: each cycle, if rem >= stride then rem -= stride and q++; else out_size = q+1, P = out_size*out_size (16 bits), and go to RUN.
- RUN: gen_enable = !stall.
  - Counters k_cnt (0..K-1, innermost), pix_cnt (0..P-1), kn_cnt (0..kernel_nums-1, outermost) advance only on cycles with gen_enable=1. Each counter wraps to 0 and carries to the next.
  - Issue tags: first = (k_cnt==0), last = (k_cnt==K-1).
  - After the beat with all three counters at their maximum, go to DRAIN; gen_enable is 0 from the next cycle.
  - Total enable beats per job = K*P*kernel_nums.
- Delay line: depth GEN_LAT; shifts every cycle regardless of stall. Carries {gen_enable, first & gen_enable, last & gen_enable} to acc_valid/acc_first/acc_last. With GEN_LAT=0 these outputs are combinational copies.
- DRAIN: wait GEN_LAT cycles, then go to DONE.
- DONE (1 cycle): pulse done, clear busy, go to IDLE. A new start is accepted on the following cycle.
- stall during CHECK, DIV or DRAIN has no effect.
- If K==1, acc_first and acc_last are both high on every beat.

Optional Feature:
CONV_SCHED_PERF_EN
- Defined: adds outputs perf_stall_cycles (32 bits, RUN cycles with stall=1) and perf_total_cycles (32 bits, cycles from leaving IDLE to done). Both clear on an accepted start, hold their value after done, and saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. tensor 4, kernel 3, ch 1, stride 1, knum 1, GEN_LAT 1 -> out_size 2; 36 gen_enable beats; 4 acc_first and 4 acc_last, with acc_last on beats 9/18/27/36; one done pulse; busy low afterward.
2. tensor 5, kernel 3, ch 2, stride 2, knum 3 -> out_size 2; K 18; 216 gen_enable beats; 12 acc_last; done once.
3. Scenario 1 with stall held high for 5 cycles mid-RUN -> gen_enable 0 during the stall; beat count still 36; done 5 cycles later than in scenario 1; with CONV_SCHED_PERF_EN defined, perf_stall_cycles = 5.
4. kernel 5 > tensor 4, and separately stride 0 -> cfg_err pulse 2 cycles after start, no gen_enable, no done, busy low; the next valid start completes normally.
5. rst asserted mid-RUN -> every output 0 on the next cycle; a fresh start for scenario 1 gives 36 beats.
6. start pulsed again while busy, with different configuration -> ignored; beat count matches the first job only; one done pulse.
